// File: rtl/logic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : logic_pipe                                                |
// | Purpose  : Two-stage bitwise truth-table ALU with accumulator and    |
// |            valid/ready flow control.                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module logic_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       sel,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc_q
);

    logic             w_stall;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_result;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_zero;
    logic             r_out_parity;
    logic [WIDTH-1:0] r_acc;

    assign w_stall  = r_out_valid && !out_ready;
    assign w_accept = in_valid && !w_stall;
    assign w_op_a   = acc_en ? r_acc : in_a;

    // Each result bit looks up sel with the {a,b} bit pair as the index.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_result[i] = sel[{w_op_a[i], in_b[i]}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_result;
            end
        end
    end

    // Flags derive from the stage-1 word so they always match out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_zero   <= 1'b0;
            r_out_parity <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= r_s1_data;
                r_out_zero   <= (r_s1_data == '0);
                r_out_parity <= ^r_s1_data;
            end
        end
    end

    // Clear wins over write-back; the operand already used the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_accept && acc_en) begin
            r_acc <= w_result;
        end
    end

    assign in_ready   = !w_stall;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_zero   = r_out_zero;
    assign out_parity = r_out_parity;
    assign acc_q      = r_acc;

endmodule
`default_nettype wire

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal >= 1).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation offered this cycle.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-006 SHALL have port in_a  input  WIDTH  operand A.
REQ-007 SHALL have port in_b  input  WIDTH  operand B.
REQ-008 SHALL have port sel  input  4  function truth table.
REQ-009 SHALL have port acc_en  input  1  replace operand A with accumulator, write result back to accumulator.
REQ-010 SHALL have port acc_clr  input  1  clear accumulator.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port out_data  output  WIDTH  result.
REQ-014 SHALL have port out_zero  output  1  out_data == 0.
REQ-015 SHALL have port out_parity  output  1  XOR-reduction of out_data.
REQ-016 SHALL have port acc_q  output  WIDTH  current accumulator value.

Function
REQ-017 SHALL compute each result bit i as sel[{a[i], b[i]}], a = effective operand A; e.g. 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1100 A, 1010 B, 0000 zero, 1111 all-ones.
REQ-018 SHALL use effective operand A = acc_q when acc_en = 1, else in_a.
REQ-019 SHALL be a two-stage pipeline: stage 1 registers result and a valid bit; stage 2 registers out_data, out_zero, out_parity and out_valid.
REQ-020 SHALL present an operation accepted in cycle N on the outputs in cycle N+2 when no stall occurs.
REQ-021 SHALL define stall = out_valid && !out_ready; in_ready = !stall; both stages advance only when !stall.
REQ-022 SHALL hold out_data, out_zero, out_parity, out_valid and stage-1 contents unchanged during stall.
REQ-023 SHALL insert a bubble (valid 0) into stage 1 when advancing with no accepted operation.
REQ-024 SHALL sustain one operation per cycle with out_ready held 1.
REQ-025 SHALL compute out_zero and out_parity from the same stage-1 result registered into out_data.
REQ-026 SHALL update the accumulator on acceptance with acc_en = 1, to that operation's result, visible on acc_q the next cycle.
REQ-027 SHALL make back-to-back accepted acc_en operations chain: each uses the accumulator written by the previous one.
REQ-028 SHALL set the accumulator to 0 on acc_clr regardless of stall; acc_clr has priority over REQ-026 write-back.
REQ-029 SHALL, when acc_clr and an accepted acc_en operation coincide, use the pre-clear accumulator as operand A and leave accumulator 0.
REQ-030 SHALL ignore acc_en, sel and operands when no operation is accepted.

Reset
REQ-031 SHALL on rst clear out_valid, stage-1 valid, out_data, out_zero, out_parity and accumulator to 0; in_ready = 1 the cycle after.
REQ-032 SHALL discard in-flight operations on rst mid-operation; no result of them appears afterwards.
REQ-033 SHALL give rst priority over acceptance, acc_clr and acc write-back in the same cycle.

Verification
REQ-034 SHALL cover: WIDTH=16, sel=1000, in_a=F0F0, in_b=FF00 accepted cycle N -> cycle N+2 out_data=F000, out_zero=0, out_parity=0.
REQ-035 SHALL cover: sel=0110, in_a=in_b=1234 -> out_data=0000, out_zero=1, out_parity=0; sel=1111 -> FFFF, parity 0; sel=1100, in_a=0001 -> 0001, parity 1.
REQ-036 SHALL cover: 3 ops streamed, out_ready=0 from first out_valid -> in_ready=0, out_data held 4 cycles; out_ready=1 -> all 3 results in order, none lost or duplicated.
REQ-037 SHALL cover: acc_clr, then 3 back-to-back acc_en ops sel=1110, in_b=0001,0002,0004 -> out_data 0001,0003,0007; acc_q=0007.
REQ-038 SHALL cover: acc_clr with accepted acc_en op (acc_q=00FF, sel=1100) -> out_data=00FF, acc_q=0000 next cycle.
REQ-039 SHALL cover: rst asserted with 2 ops in flight and acc_q=0007 -> out_valid=0, acc_q=0000, no stale result after release.
